ddr_frame_arbiter: RTL and testbench
====================================

Name: ddr_frame_arbiter

Overview:
- Schedules DDR burst commands for the frame-buffer path.
- Shares one DDR user command port between the camera write channel (write FIFO drained into DDR) and the ethernet read channel (DDR read into read FIFO).
- Builds burst addresses as {bank, offset} from the bank selected by bank_switch.
- Emits the frame_wr_done / frame_rd_done pulses that bank_switch consumes.

Parameters:
- ADDR_W, 25, DDR word address width; bank occupies [ADDR_W-1:ADDR_W-2].
- BURST_LEN, 64, words per DDR burst; power of two.
- FRAME_WORDS, 393216, words per frame; must be a multiple of BURST_LEN and below 2^(ADDR_W-2).
- CNT_W, 11, width of the FIFO level inputs.
- FIFO_DEPTH, 1024, read FIFO depth in words.

Ports:
- phy_clk  in  1  system clock; all logic on its rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- wr_bank  in  2  write bank from bank_switch.
- wr_load  in  1  one-cycle pulse: start a new write frame in wr_bank.
- rd_bank  in  2  read bank from bank_switch.
- rd_load  in  1  one-cycle pulse: start a new read frame in rd_bank.
- wr_fifo_cnt  in  CNT_W  words available in the write FIFO.
- rd_fifo_cnt  in  CNT_W  words used in the read FIFO.
- cmd_valid  out  1  command request to DDR user interface.
- cmd_ready  in  1  DDR accepts the command when cmd_valid&cmd_ready.
- cmd_wr  out  1  1 = write burst, 0 = read burst.
- cmd_addr  out  ADDR_W  burst start address {bank, offset}.
- burst_done  in  1  one-cycle pulse: the accepted burst has fully completed.
- frame_wr_done  out  1  one-cycle pulse: last write burst of the frame completed.
- frame_rd_done  out  1  one-cycle pulse: last read burst of the frame completed.
- busy  out  1  a burst is outstanding (command issued, burst_done not yet seen).

Behaviour:
- Reset: all outputs 0; FSM in IDLE; offsets 0; both frame-active flags 0; load-pending flags 0; last_grant = read.
- wr_load/rd_load are captured into pending flags in any state.
- Pending flags are applied only in IDLE: latch bank, clear offset, set frame-active, clear pending. Application takes one cycle and no grant is made that cycle.
- Write request = wr_active & (wr_fifo_cnt >= BURST_LEN).
- Read request = rd_active & (FIFO_DEPTH - rd_fifo_cnt >= BURST_LEN).
- FSM states:
  - IDLE: apply pending loads, else go to ARB.
  - ARB: no requests -> stay in ARB, re-evaluate every cycle (pending loads send it back to IDLE). One request -> grant it. Both -> grant the opposite of last_grant (round-robin).
  - CMD: cmd_valid=1, cmd_wr and cmd_addr held stable until cmd_ready; on handshake go to WAIT, busy=1.
  - WAIT: on burst_done, busy=0, offset += BURST_LEN, last_grant updated, go to IDLE.
- If the new offset equals FRAME_WORDS: pulse the matching frame_*_done in the cycle after burst_done, clear frame-active, and issue no further bursts on that channel until its next load.
- Latency: from a request in ARB to cmd_valid is 1 cycle; from burst_done to the next cmd_valid is at least 3 cycles.
- A load arriving mid-burst does not abort the burst. It completes to its original address, the offset advances, and then the load is applied in IDLE. Any frame_done owed by that burst is still emitted.
- Simultaneous wr_load and rd_load are both applied in the same IDLE cycle.
- Offset arithmetic is (ADDR_W-2) bits and never wraps within a frame because of the FRAME_WORDS constraint.
- burst_done outside WAIT is ignored.
- cmd_ready while cmd_valid=0 is ignored.

Optional Feature:
- Macro ARB_WR_PRIORITY_EN.
- Defined: fixed priority; a write request always wins ARB over a read request, and last_grant is unused. This protects camera data from overflow.
- Undefined: round-robin as described above.

Test Plan:
- Reset, then wr_load with wr_bank=2, wr_fifo_cnt=64, cmd_ready=1 -> cmd_valid with cmd_wr=1 and cmd_addr=0x1000000. After burst_done, the next write goes to 0x1000040.
- FRAME_WORDS=256, BURST_LEN=64, write channel only -> 4 bursts, then frame_wr_done for exactly 1 cycle after the 4th burst_done. No 5th command while wr_fifo_cnt stays at 64.
- Both channels requesting continuously, rd_bank=1, wr_bank=0 -> commands alternate W,R,W,R, read addresses 0x0800000, 0x0800040. With ARB_WR_PRIORITY_EN defined -> all writes.
- rd_fifo_cnt=961 (space 63) -> no read issued. Drop it to 960 -> read cmd_valid 1 cycle after ARB re-evaluates.
- wr_load pulsed during WAIT of a burst at offset 0x40 -> that burst completes, and the next write address is {new wr_bank, 0}.
- cmd_ready held low 5 cycles -> cmd_valid, cmd_wr and cmd_addr stable throughout. sys_rst asserted mid-WAIT -> all outputs 0 immediately; no frame_done afterwards.

Source files
------------

// File: rtl/ddr_frame_arbiter.sv
// ----------------------------------------------------------------------------
// ddr_frame_arbiter
//
// Purpose:
//   Shares one DDR user command port between the camera write channel (write
//   FIFO drained into DDR) and the ethernet read channel (DDR read into the
//   read FIFO). Each channel walks a frame of FRAME_WORDS words in BURST_LEN
//   bursts at {bank, offset}, and the channel raises a one-cycle
//   frame_*_done pulse when its last burst of the frame has completed.
//
// Ports:
//   phy_clk, sys_rst          clock (rising edge), async active-high reset
//   wr_bank, wr_load          write bank and one-cycle "new write frame" pulse
//   rd_bank, rd_load          read bank and one-cycle "new read frame" pulse
//   wr_fifo_cnt               words available in the write FIFO
//   rd_fifo_cnt               words used in the read FIFO
//   cmd_valid, cmd_ready      command handshake toward the DDR user interface
//   cmd_wr, cmd_addr          burst direction (1 = write) and start address
//   burst_done                one-cycle pulse: accepted burst fully completed
//   frame_wr_done/rd_done     one-cycle pulses: frame finished on that channel
//   busy                      a burst is outstanding
//
// Handshake: a command transfers on a rising edge where cmd_valid and
//   cmd_ready are both high; cmd_wr and cmd_addr stay constant while
//   cmd_valid is high and waiting. cmd_ready with cmd_valid low is ignored,
//   as is burst_done outside the WAIT state.
//
// Build option:
//   ARB_WR_PRIORITY_EN  defined: writes always win arbitration.
//                       undefined (default): round-robin on last grant.
// ----------------------------------------------------------------------------
module ddr_frame_arbiter #(
    parameter int ADDR_W      = 25,
    parameter int BURST_LEN   = 64,
    parameter int FRAME_WORDS = 393216,
    parameter int CNT_W       = 11,
    parameter int FIFO_DEPTH  = 1024
) (
    input  logic              phy_clk,
    input  logic              sys_rst,
    input  logic [1:0]        wr_bank,
    input  logic              wr_load,
    input  logic [1:0]        rd_bank,
    input  logic              rd_load,
    input  logic [CNT_W-1:0]  wr_fifo_cnt,
    input  logic [CNT_W-1:0]  rd_fifo_cnt,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_wr,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              burst_done,
    output logic              frame_wr_done,
    output logic              frame_rd_done,
    output logic              busy
);

    localparam int OFF_W = ADDR_W - 2;
    localparam logic [OFF_W-1:0] BURST_OFF = OFF_W'(BURST_LEN);
    localparam logic [OFF_W-1:0] FRAME_OFF = OFF_W'(FRAME_WORDS);
    localparam logic [31:0]      BURST_U   = BURST_LEN;
    localparam logic [31:0]      DEPTH_U   = FIFO_DEPTH;

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_CMD, S_WAIT} state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic               r_wr_pend, r_rd_pend;
    logic               r_wr_active, r_rd_active;
    logic [1:0]         r_wr_bank_q, r_rd_bank_q;
    logic [OFF_W-1:0]   r_wr_off, r_rd_off;
    logic               r_cmd_wr;
    logic [ADDR_W-1:0]  r_cmd_addr;
    logic               r_frame_wr_done, r_frame_rd_done;
`ifndef ARB_WR_PRIORITY_EN
    logic               r_last_wr;      // 1 = last completed burst was a write
`endif

    logic               w_wr_req, w_rd_req;
    logic               w_apply, w_grant, w_grant_wr, w_done;
    logic [OFF_W-1:0]   w_wr_off_next, w_rd_off_next;

    // Widen to 32 bits so a read FIFO count above FIFO_DEPTH cannot wrap
    // the free-space test into a false request.
    assign w_wr_req = r_wr_active &
                      ({{(32-CNT_W){1'b0}}, wr_fifo_cnt} >= BURST_U);
    assign w_rd_req = r_rd_active &
                      (({{(32-CNT_W){1'b0}}, rd_fifo_cnt} + BURST_U) <= DEPTH_U);

    assign w_wr_off_next = r_wr_off + BURST_OFF;
    assign w_rd_off_next = r_rd_off + BURST_OFF;

    assign cmd_valid     = (r_state == S_CMD);
    assign busy          = (r_state == S_WAIT);
    assign cmd_wr        = r_cmd_wr;
    assign cmd_addr      = r_cmd_addr;
    assign frame_wr_done = r_frame_wr_done;
    assign frame_rd_done = r_frame_rd_done;

    // ---------------- FSM state register ----------------
    always_ff @(posedge phy_clk or posedge sys_rst) begin
        if (sys_rst) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // ---------------- FSM next state / control strobes ----------------
    always_comb begin
        w_state_next = r_state;
        w_apply      = 1'b0;
        w_grant      = 1'b0;
        w_grant_wr   = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Loads are only applied here, so a burst in flight always
                // finishes against the frame it was issued for.
                w_apply      = 1'b1;
                w_state_next = S_ARB;
            end
            S_ARB: begin
                if (r_wr_pend | r_rd_pend) begin
                    w_state_next = S_IDLE;
                end else if (w_wr_req | w_rd_req) begin
                    w_grant      = 1'b1;
`ifdef ARB_WR_PRIORITY_EN
                    w_grant_wr   = w_wr_req;
`else
                    w_grant_wr   = w_wr_req & (~w_rd_req | ~r_last_wr);
`endif
                    w_state_next = S_CMD;
                end
            end
            S_CMD: begin
                if (cmd_ready) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (burst_done) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge phy_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wr_pend       <= 1'b0;
            r_rd_pend       <= 1'b0;
            r_wr_active     <= 1'b0;
            r_rd_active     <= 1'b0;
            r_wr_bank_q     <= 2'b00;
            r_rd_bank_q     <= 2'b00;
            r_wr_off        <= '0;
            r_rd_off        <= '0;
            r_cmd_wr        <= 1'b0;
            r_cmd_addr      <= '0;
            r_frame_wr_done <= 1'b0;
            r_frame_rd_done <= 1'b0;
`ifndef ARB_WR_PRIORITY_EN
            r_last_wr       <= 1'b0;
`endif
        end else begin
            r_frame_wr_done <= 1'b0;
            r_frame_rd_done <= 1'b0;

            // A load arriving in the same cycle it would be cleared stays
            // pending and is applied again on the next IDLE visit.
            if (wr_load)      r_wr_pend <= 1'b1;
            else if (w_apply) r_wr_pend <= 1'b0;
            if (rd_load)      r_rd_pend <= 1'b1;
            else if (w_apply) r_rd_pend <= 1'b0;

            if (w_apply && r_wr_pend) begin
                r_wr_bank_q <= wr_bank;
                r_wr_off    <= '0;
                r_wr_active <= 1'b1;
            end
            if (w_apply && r_rd_pend) begin
                r_rd_bank_q <= rd_bank;
                r_rd_off    <= '0;
                r_rd_active <= 1'b1;
            end

            if (w_grant) begin
                r_cmd_wr   <= w_grant_wr;
                r_cmd_addr <= w_grant_wr ? {r_wr_bank_q, r_wr_off}
                                         : {r_rd_bank_q, r_rd_off};
            end

            // r_cmd_wr still names the channel of the outstanding burst.
            if (w_done) begin
                if (r_cmd_wr) begin
                    r_wr_off <= w_wr_off_next;
                    if (w_wr_off_next == FRAME_OFF) begin
                        r_frame_wr_done <= 1'b1;
                        r_wr_active     <= 1'b0;
                    end
                end else begin
                    r_rd_off <= w_rd_off_next;
                    if (w_rd_off_next == FRAME_OFF) begin
                        r_frame_rd_done <= 1'b1;
                        r_rd_active     <= 1'b0;
                    end
                end
`ifndef ARB_WR_PRIORITY_EN
                r_last_wr <= r_cmd_wr;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ddr_frame_arbiter
//
// Bench for ddr_frame_arbiter built with FRAME_WORDS = 256 (four 64-word
// bursts per frame). Inputs change on the falling edge, outputs are sampled
// on the falling edge. Honours ARB_WR_PRIORITY_EN when defined.
// ----------------------------------------------------------------------------
module tb_ddr_frame_arbiter;

  localparam int T_BURST = 64;
  localparam int T_FRAME = 256;
  localparam int T_DEPTH = 1024;

  logic        phy_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [1:0]  wr_bank = 2'd0;
  logic        wr_load = 1'b0;
  logic [1:0]  rd_bank = 2'd0;
  logic        rd_load = 1'b0;
  logic [10:0] wr_fifo_cnt = 11'd0;
  logic [10:0] rd_fifo_cnt = 11'd1024;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        cmd_wr;
  logic [24:0] cmd_addr;
  logic        burst_done = 1'b0;
  logic        frame_wr_done;
  logic        frame_rd_done;
  logic        busy;

  ddr_frame_arbiter #(
    .ADDR_W(25), .BURST_LEN(T_BURST), .FRAME_WORDS(T_FRAME),
    .CNT_W(11), .FIFO_DEPTH(T_DEPTH)
  ) dut (
    .phy_clk(phy_clk), .sys_rst(sys_rst),
    .wr_bank(wr_bank), .wr_load(wr_load),
    .rd_bank(rd_bank), .rd_load(rd_load),
    .wr_fifo_cnt(wr_fifo_cnt), .rd_fifo_cnt(rd_fifo_cnt),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .burst_done(burst_done),
    .frame_wr_done(frame_wr_done), .frame_rd_done(frame_rd_done),
    .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 phy_clk = ~phy_clk;

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int exp_done_total = 0;
  int obs_done_total = 0;
  logic [25:0] exp_q[$];   // {cmd_wr, cmd_addr} predicted by the model

  always @(negedge phy_clk)
    if (!sys_rst) obs_done_total += int'(frame_wr_done) + int'(frame_rd_done);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_loads(input logic lw, input logic [1:0] wb,
                             input logic lr, input logic [1:0] rb);
    if (lw) wr_bank = wb;
    if (lr) rd_bank = rb;
    wr_load = lw;
    rd_load = lr;
    @(negedge phy_clk);
    wr_load = 1'b0;
    rd_load = 1'b0;
  endtask

  task automatic no_req_counts();
    wr_fifo_cnt = 11'd0;
    rd_fifo_cnt = 11'd1024;
  endtask

  // Waits for a command, checks it, holds ready low rdy_dly cycles checking
  // stability, then accepts it.
  task automatic do_cmd(input logic exp_wr, input logic [24:0] exp_addr, input int rdy_dly);
    int t;
    t = 0;
    while (cmd_valid !== 1'b1 && t < 40) begin
      @(negedge phy_clk);
      t++;
    end
    check("cmd_valid_seen", {31'd0, cmd_valid}, 32'd1);
    if (cmd_valid !== 1'b1) return;
    check("cmd_wr", {31'd0, cmd_wr}, {31'd0, exp_wr});
    check("cmd_addr", {7'd0, cmd_addr}, {7'd0, exp_addr});
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge phy_clk);
      check("stall_stable", {5'd0, cmd_valid, cmd_wr, cmd_addr}, {5'd0, 1'b1, exp_wr, exp_addr});
    end
    cmd_ready = 1'b1;
    @(negedge phy_clk);
    cmd_ready = 1'b0;
    check("busy_after_accept", {30'd0, busy, cmd_valid}, 32'd2);
  endtask

  task automatic finish_burst(input logic ew, input logic er);
    burst_done = 1'b1;
    @(negedge phy_clk);
    burst_done = 1'b0;
    check("frame_wr_done", {31'd0, frame_wr_done}, {31'd0, ew});
    check("frame_rd_done", {31'd0, frame_rd_done}, {31'd0, er});
    check("busy_after_done", {31'd0, busy}, 32'd0);
    exp_done_total += int'(ew) + int'(er);
    @(negedge phy_clk);
    check("done_pulse_width", {30'd0, frame_wr_done, frame_rd_done}, 32'd0);
  endtask

  // ---------------- reference model (transaction level) ----------------
  int m_wr_act, m_rd_act, m_wr_bank, m_rd_bank, m_wr_off, m_rd_off, m_last_wr, m_cur_wr;

  task automatic model_reset();
    m_wr_act = 0; m_rd_act = 0; m_wr_bank = 0; m_rd_bank = 0;
    m_wr_off = 0; m_rd_off = 0; m_last_wr = 0; m_cur_wr = 0;
  endtask

  task automatic model_load(input logic lw, input int wb, input logic lr, input int rb);
    if (lw) begin m_wr_act = 1; m_wr_bank = wb; m_wr_off = 0; end
    if (lr) begin m_rd_act = 1; m_rd_bank = rb; m_rd_off = 0; end
  endtask

  // Decides which burst the current FIFO levels should produce next.
  task automatic model_pick(output logic has);
    logic wq, rq, iw;
    int   a;
    wq = (m_wr_act != 0) && (int'(wr_fifo_cnt) >= T_BURST);
    rq = (m_rd_act != 0) && (T_DEPTH - int'(rd_fifo_cnt) >= T_BURST);
    has = wq | rq;
    if (wq && rq) begin
`ifdef ARB_WR_PRIORITY_EN
      iw = 1'b1;
`else
      iw = (m_last_wr == 0);
`endif
    end else begin
      iw = wq;
    end
    if (has) begin
      a = iw ? (m_wr_bank * (1 << 23) + m_wr_off) : (m_rd_bank * (1 << 23) + m_rd_off);
      exp_q.push_back({iw, 25'(a)});
      m_cur_wr = int'(iw);
    end
  endtask

  task automatic model_done(output logic ew, output logic er);
    ew = 1'b0;
    er = 1'b0;
    if (m_cur_wr != 0) begin
      m_wr_off += T_BURST;
      if (m_wr_off == T_FRAME) begin ew = 1'b1; m_wr_act = 0; end
      m_last_wr = 1;
    end else begin
      m_rd_off += T_BURST;
      if (m_rd_off == T_FRAME) begin er = 1'b1; m_rd_act = 0; end
      m_last_wr = 0;
    end
  endtask

  task automatic rand_counts();
    case ($urandom_range(0, 3))
      0: wr_fifo_cnt = 11'd63;
      1: wr_fifo_cnt = 11'd64;
      2: wr_fifo_cnt = 11'd0;
      default: wr_fifo_cnt = 11'($urandom_range(0, 2047));
    endcase
    case ($urandom_range(0, 4))
      0: rd_fifo_cnt = 11'd960;
      1: rd_fifo_cnt = 11'd961;
      2: rd_fifo_cnt = 11'd1024;
      3: rd_fifo_cnt = 11'd0;
      default: rd_fifo_cnt = 11'($urandom_range(0, 2047));
    endcase
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [10:0] wr_cnt;
    logic [10:0] rd_cnt;
    logic        exp_valid;
    logic        exp_wr;
  } vec_t;

  vec_t tbl[9];

  // ---------------- main sequence ----------------
  initial begin
    logic        seen, has, ew, er, ml, mlw, mlr;
    logic [1:0]  b1, b2;
    logic [25:0] e;
    logic        c_w[4];
    logic [24:0] c_a[4];
    logic        c_done_wr;

    tbl[0] = '{11'd0,    11'd1024, 1'b0, 1'b0};
    tbl[1] = '{11'd63,   11'd961,  1'b0, 1'b0};
    tbl[2] = '{11'd64,   11'd1024, 1'b1, 1'b1};
    tbl[3] = '{11'd0,    11'd960,  1'b1, 1'b0};
    tbl[4] = '{11'd2047, 11'd2047, 1'b1, 1'b1};
`ifdef ARB_WR_PRIORITY_EN
    tbl[5] = '{11'd64,   11'd0,    1'b1, 1'b1};
`else
    tbl[5] = '{11'd64,   11'd0,    1'b1, 1'b0};
`endif
    tbl[6] = '{11'd100,  11'd500,  1'b1, 1'b1};
    tbl[7] = '{11'd0,    11'd0,    1'b1, 1'b0};
    tbl[8] = '{11'd63,   11'd961,  1'b0, 1'b0};

`ifdef ARB_WR_PRIORITY_EN
    c_w = '{1'b1, 1'b1, 1'b1, 1'b1};
    c_a = '{25'h0000000, 25'h0000040, 25'h0000080, 25'h00000C0};
    c_done_wr = 1'b1;
`else
    c_w = '{1'b1, 1'b0, 1'b1, 1'b0};
    c_a = '{25'h0000000, 25'h0800000, 25'h0000040, 25'h0800040};
    c_done_wr = 1'b0;
`endif

    // ---- reset ----
    repeat (3) @(negedge phy_clk);
    check("rst_outputs_in_reset",
          {5'd0, cmd_valid, cmd_wr, busy, frame_wr_done, frame_rd_done, 2'd0, cmd_addr[19:0]}, 32'd0);
    sys_rst = 1'b0;
    @(negedge phy_clk);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_cmd_wr", {31'd0, cmd_wr}, 32'd0);
    check("rst_cmd_addr", {7'd0, cmd_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {30'd0, frame_wr_done, frame_rd_done}, 32'd0);

    // ---- table: one ARB decision per row, channels reloaded each row ----
    for (int i = 0; i < 9; i++) begin
      no_req_counts();
      pulse_loads(1'b1, 2'd2, 1'b1, 2'd1);
      repeat (3) @(negedge phy_clk);
      wr_fifo_cnt = tbl[i].wr_cnt;
      rd_fifo_cnt = tbl[i].rd_cnt;
      @(negedge phy_clk);
      check($sformatf("tbl%0d_valid", i), {31'd0, cmd_valid}, {31'd0, tbl[i].exp_valid});
      no_req_counts();
      if (tbl[i].exp_valid && cmd_valid === 1'b1) begin
        check($sformatf("tbl%0d_wr", i), {31'd0, cmd_wr}, {31'd0, tbl[i].exp_wr});
        check($sformatf("tbl%0d_addr", i), {7'd0, cmd_addr},
              tbl[i].exp_wr ? 32'h1000000 : 32'h0800000);
        cmd_ready = 1'b1;
        @(negedge phy_clk);
        cmd_ready = 1'b0;
        @(negedge phy_clk);
        finish_burst(1'b0, 1'b0);
      end
    end

    // ---- both channels requesting continuously ----
    no_req_counts();
    pulse_loads(1'b1, 2'd0, 1'b1, 2'd1);
    repeat (3) @(negedge phy_clk);
    wr_fifo_cnt = 11'd64;
    rd_fifo_cnt = 11'd0;
    for (int i = 0; i < 4; i++) begin
      do_cmd(c_w[i], c_a[i], 0);
      if (i == 3) no_req_counts();
      @(negedge phy_clk);
      finish_burst((i == 3) ? c_done_wr : 1'b0, 1'b0);
    end

    // ---- write-only frame: 4 bursts, done pulse, no 5th command ----
    no_req_counts();
    pulse_loads(1'b1, 2'd2, 1'b0, 2'd0);
    repeat (3) @(negedge phy_clk);
    wr_fifo_cnt = 11'd64;
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b1, 25'h1000000 + 25'(i * 64), (i == 0) ? 5 : 0);
      repeat (i + 1) @(negedge phy_clk);
      finish_burst(i == 3, 1'b0);
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge phy_clk);
      if (cmd_valid === 1'b1) seen = 1'b1;
    end
    check("no_5th_write", {31'd0, seen}, 32'd0);

    // ---- read free-space threshold ----
    no_req_counts();
    pulse_loads(1'b0, 2'd0, 1'b1, 2'd1);
    repeat (3) @(negedge phy_clk);
    rd_fifo_cnt = 11'd961;
    seen = 1'b0;
    repeat (6) begin
      @(negedge phy_clk);
      if (cmd_valid === 1'b1) seen = 1'b1;
    end
    check("rd_space_63_no_cmd", {31'd0, seen}, 32'd0);
    rd_fifo_cnt = 11'd960;
    @(negedge phy_clk);
    check("rd_space_64_latency", {31'd0, cmd_valid}, 32'd1);
    do_cmd(1'b0, 25'h0800000, 0);
    rd_fifo_cnt = 11'd1024;
    @(negedge phy_clk);
    finish_burst(1'b0, 1'b0);

    // ---- write load during WAIT of the burst at offset 0x40 ----
    no_req_counts();
    pulse_loads(1'b1, 2'd3, 1'b0, 2'd0);
    repeat (3) @(negedge phy_clk);
    wr_fifo_cnt = 11'd64;
    do_cmd(1'b1, 25'h1800000, 0);
    @(negedge phy_clk);
    finish_burst(1'b0, 1'b0);
    do_cmd(1'b1, 25'h1800040, 0);
    pulse_loads(1'b1, 2'd0, 1'b0, 2'd0);
    finish_burst(1'b0, 1'b0);
    do_cmd(1'b1, 25'h0000000, 0);
    wr_fifo_cnt = 11'd0;
    @(negedge phy_clk);
    finish_burst(1'b0, 1'b0);

    // ---- reset during WAIT of the frame's last burst ----
    no_req_counts();
    pulse_loads(1'b1, 2'd1, 1'b0, 2'd0);
    repeat (3) @(negedge phy_clk);
    wr_fifo_cnt = 11'd64;
    for (int i = 0; i < 3; i++) begin
      do_cmd(1'b1, 25'h0800000 + 25'(i * 64), 0);
      @(negedge phy_clk);
      finish_burst(1'b0, 1'b0);
    end
    do_cmd(1'b1, 25'h08000C0, 0);
    wr_fifo_cnt = 11'd0;
    @(negedge phy_clk);
    sys_rst = 1'b1;
    #1;
    check("async_rst_outputs", {2'd0, cmd_valid, cmd_wr, busy, frame_wr_done, frame_rd_done, cmd_addr},
          32'd0);
    @(negedge phy_clk);
    sys_rst = 1'b0;
    burst_done = 1'b1;
    @(negedge phy_clk);
    burst_done = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge phy_clk);
      if (frame_wr_done === 1'b1 || frame_rd_done === 1'b1 || cmd_valid === 1'b1) seen = 1'b1;
    end
    check("no_done_after_rst", {31'd0, seen}, 32'd0);

    // ---- randomized traffic against the model ----
    model_reset();
    no_req_counts();
    for (int it = 0; it < 200; it++) begin
      model_pick(has);
      if (!has) begin
        seen = 1'b0;
        repeat (4) begin
          @(negedge phy_clk);
          if (cmd_valid === 1'b1) seen = 1'b1;
        end
        check("rand_idle_no_cmd", {31'd0, seen}, 32'd0);
        no_req_counts();
        mlw = ($urandom_range(0, 2) != 0);
        mlr = ($urandom_range(0, 2) != 0);
        b1 = 2'($urandom_range(0, 3));
        b2 = 2'($urandom_range(0, 3));
        pulse_loads(mlw, b1, mlr, b2);
        model_load(mlw, int'(b1), mlr, int'(b2));
        repeat (3) @(negedge phy_clk);
        rand_counts();
      end else begin
        e = exp_q.pop_front();
        do_cmd(e[25], e[24:0], $urandom_range(0, 3));
        ml  = ($urandom_range(0, 3) == 0);
        mlw = ml && ($urandom_range(0, 1) == 1);
        mlr = ml && !mlw ? 1'b1 : (ml && ($urandom_range(0, 1) == 1));
        b1 = 2'($urandom_range(0, 3));
        b2 = 2'($urandom_range(0, 3));
        if (ml) pulse_loads(mlw, b1, mlr, b2);
        repeat ($urandom_range(0, 3)) @(negedge phy_clk);
        if ($urandom_range(0, 1) == 1) rand_counts();
        model_done(ew, er);
        finish_burst(ew, er);
        if (ml) model_load(mlw, int'(b1), mlr, int'(b2));
      end
    end
    no_req_counts();
    repeat (6) @(negedge phy_clk);

    check("frame_done_total", 32'(obs_done_total), 32'(exp_done_total));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
